code_compare: RTL

CODE_COMPARE -- requirements
Module: code_compare

---
 rtl/code_pkg.sv | 40 ++++
 rtl/key_edge.sv | 20 ++
 rtl/code_compare.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/code_pkg.sv
// Shared definitions for the keypad code comparator: digit width, key codes,
// compare-target encodings, the fixed programming code and the power-on user code.
package code_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned MIN_LEN_DEF = 4;

  localparam logic [DIGIT_W-1:0] KEY_NONE      = 4'hF;
  localparam logic [DIGIT_W-1:0] KEY_CANCEL    = 4'h7;
  localparam logic [DIGIT_W-1:0] KEY_PROG      = 4'h8;
  localparam logic [DIGIT_W-1:0] KEY_LOCK      = 4'h9;
  localparam logic [DIGIT_W-1:0] KEY_DIGIT_MAX = 4'h6;

  localparam logic [1:0] CT_PC   = 2'b00;
  localparam logic [1:0] CT_UC   = 2'b01;
  localparam logic [1:0] CT_CAND = 2'b10;
  localparam logic [1:0] CT_NONE = 2'b11;

  // Element 0 is the first digit entered: 6,5,4,3,2,1,0,6
  localparam int unsigned PC_LEN = 8;
  localparam logic [PC_LEN-1:0][DIGIT_W-1:0] PC_CODE =
    {4'd6, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};

  // Element 0 is the first digit: 1,2,3,4
  localparam int unsigned DEFAULT_UC_LEN = 4;
  localparam logic [DEFAULT_UC_LEN-1:0][DIGIT_W-1:0] DEFAULT_UC =
    {4'd4, 4'd3, 4'd2, 4'd1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_DONE
  } cmp_state_t;

  function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
    return key <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Keypad press detector: one pulse per idle->key transition, held keys do not repeat.
module key_edge
  import code_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] button,
  output logic               press_c
);

  logic [DIGIT_W-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= KEY_NONE;
    else     prev <= button;
  end

  assign press_c = (prev == KEY_NONE) && (button != KEY_NONE);

endmodule

// File: rtl/code_compare.sv
// Keypad code entry buffer with sequential digit-by-digit compare against the
// programming code, user code or captured candidate. CODE_CMP_CONST_TIME_EN
// makes every compare run for MAX_LEN cycles independent of the entry length.
module code_compare
  import code_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned MIN_LEN = MIN_LEN_DEF
) (
  input  logic               hwclk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] button,
  input  logic               read_input,
  input  logic               store,
  input  logic [1:0]         compareType,
  output logic               data_ready,
  output logic               correct_input,
  output logic               validLength,
  output logic               validLengthPC
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [MAX_LEN-1:0][DIGIT_W-1:0] PC_ARR = (MAX_LEN*DIGIT_W)'(PC_CODE);
  localparam logic [MAX_LEN-1:0][DIGIT_W-1:0] UC_RST = (MAX_LEN*DIGIT_W)'(DEFAULT_UC);

  logic                              press_c;
  logic                              rd_prev, store_prev, cap_pend;
  logic                              rd_rise, rd_fall, store_rise, cap_req, do_cap;
  logic [MAX_LEN-1:0][DIGIT_W-1:0]   entry, entry_n, cand, uc, tgt;
  logic [CW-1:0]                     count, count_n, cand_len, uc_len, tlen;
  logic                              ovf, ovf_n;
  logic [1:0]                        tsel, sel, sel_n;
  cmp_state_t                        state, state_n;
  logic [IW-1:0]                     idx, idx_n, last_idx;
  logic                              match, match_n;

  key_edge u_key_edge (
    .clk     (hwclk),
    .rst     (rst),
    .button  (button),
    .press_c (press_c)
  );

  assign rd_rise    = read_input & ~rd_prev;
  assign rd_fall    = ~read_input & rd_prev;
  assign store_rise = store & ~store_prev;
  assign cap_req    = press_c && (button == KEY_PROG) && read_input && (compareType == CT_NONE);
  // A store edge wins the cycle; a colliding capture is deferred by one cycle
  assign do_cap     = (cap_req && !store_rise) || cap_pend;

  // Entry buffer next state
  always_comb begin
    entry_n = entry;
    count_n = count;
    ovf_n   = ovf;
    if (rd_rise || do_cap) begin
      entry_n = '0;
      count_n = '0;
      ovf_n   = 1'b0;
    end else if (press_c && read_input && is_digit(button)) begin
      if (count == CW'(MAX_LEN)) begin
        ovf_n = 1'b1;
      end else begin
        entry_n[IW'(count)] = button;
        count_n             = count + CW'(1);
      end
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      rd_prev       <= 1'b0;
      store_prev    <= 1'b0;
      cap_pend      <= 1'b0;
      entry         <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      cand          <= '0;
      cand_len      <= '0;
      uc            <= UC_RST;
      uc_len        <= CW'(DEFAULT_UC_LEN);
      validLength   <= 1'b0;
      validLengthPC <= 1'b0;
    end else begin
      rd_prev       <= read_input;
      store_prev    <= store;
      cap_pend      <= cap_req && store_rise;
      entry         <= entry_n;
      count         <= count_n;
      ovf           <= ovf_n;
      validLength   <= !ovf_n && (count_n >= CW'(MIN_LEN));
      validLengthPC <= !ovf_n && (count_n == CW'(PC_LEN));
      if (store_rise) begin
        uc     <= cand;
        uc_len <= cand_len;
      end
      if (do_cap) begin
        cand     <= entry;
        cand_len <= count;
      end
    end
  end

  // Compare target: live select while idle, latched select while comparing
  always_comb begin
    tsel = (state == ST_IDLE) ? compareType : sel;
    tgt  = '0;
    tlen = '0;
    case (tsel)
      CT_PC:   begin tgt = PC_ARR; tlen = CW'(PC_LEN); end
      CT_UC:   begin tgt = uc;     tlen = uc_len;      end
      CT_CAND: begin tgt = cand;   tlen = cand_len;    end
      default: ;
    endcase
  end

`ifdef CODE_CMP_CONST_TIME_EN
  assign last_idx = IW'(MAX_LEN - 1);
`else
  assign last_idx = IW'(count - CW'(1));
`endif

  // Compare FSM next state
  always_comb begin
    state_n = state;
    idx_n   = idx;
    match_n = match;
    sel_n   = sel;
    case (state)
      ST_IDLE: begin
        if (rd_fall) begin
          sel_n   = compareType;
          idx_n   = '0;
          match_n = (count == tlen) && (compareType != CT_NONE) && (count != '0);
`ifdef CODE_CMP_CONST_TIME_EN
          state_n = ST_COMPARE;
`else
          state_n = (count == '0) ? ST_DONE : ST_COMPARE;
`endif
        end
      end
      ST_COMPARE: begin
        if (rd_rise) begin
          state_n = ST_IDLE;
        end else begin
          if ((CW'(idx) < count) && (entry[idx] != tgt[idx])) match_n = 1'b0;
          if (idx == last_idx) state_n = ST_DONE;
          else                 idx_n   = idx + IW'(1);
        end
      end
      ST_DONE: begin
        if (rd_rise) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      idx           <= '0;
      match         <= 1'b0;
      sel           <= CT_NONE;
      data_ready    <= 1'b0;
      correct_input <= 1'b0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      match         <= match_n;
      sel           <= sel_n;
      data_ready    <= (state_n == ST_DONE);
      correct_input <= (state_n == ST_DONE) && match_n;
    end
  end

endmodule
